led_page_scanner: RTL and testbench
===================================

Name: led_page_scanner

Overview:
Parametrised successor to the CPU board's byte-select LED display. It shows NUM_CH data words plus a flag page on an LED_W-bit LED bank. Pages come from a manual select or from a timed auto-scan, and can be taken from live data or from a frozen snapshot. It sits between the CPU datapath (register/ALU outputs, OF/ZF) and the board LED pins.

Parameters:
DATA_W, 32, width of each data channel; must be a multiple of LED_W
NUM_CH, 2, number of data channels
LED_W, 8, LED bank width (>=2)
DWELL, 50_000_000, clock cycles per page in auto-scan (>=1)
Derived (localparam): LPC = DATA_W/LED_W; NPAGE = NUM_CH*LPC + 1; PW = $clog2(NPAGE)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
din  in  NUM_CH*DATA_W  channel data; channel c occupies din[c*DATA_W +: DATA_W]
ofa  in  1  overflow flag
zfa  in  1  zero flag
sel  in  PW  manual page select
mode  in  2  bit0 = auto-scan, bit1 = display frozen snapshot
snap  in  1  single-cycle pulse: capture din/ofa/zfa into shadow
step  in  1  single-cycle pulse: advance one page (auto mode only)
LED  out  LED_W  registered LED drive
page  out  PW  page currently shown on LED

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (async, rst_n=0): LED=0, page=0, dwell counter=0, shadow data/flags=0.
- Page map:
  - Page p < NPAGE-1: channel p/LPC, slice [(p%LPC)*LED_W +: LED_W].
  - Page NPAGE-1 (flag page): LED[0]=zfa, LED[LED_W-1]=ofa, all other bits 0.
- Source: mode[1]=0 uses live din/ofa/zfa; mode[1]=1 uses shadow.
- Snapshot: on snap=1 at a clock edge, shadow <= {din, ofa, zfa}. Shadow holds until the next snap or reset. snap is honoured in every mode.
- Manual (mode[0]=0):
  - page <= sel each cycle.
  - sel >= NPAGE maps to the flag page.
  - Dwell counter held at 0.
  - step is ignored.
- Auto (mode[0]=1):
  - Dwell counter counts 0..DWELL-1.
  - At DWELL-1: counter <= 0 and page <= (page==NPAGE-1) ? 0 : page+1.
  - step=1: same advance, and counter <= 0.
  - step coincident with dwell expiry gives a single advance.
  - Entering auto continues from the current page value; the counter starts at 0.
- Output: LED is registered from the page value and source as they stand after the update. Latency:
  - 1 cycle from a sel change, page advance or live-data change to LED.
  - 1 cycle from snap to LED when mode[1]=1 (shadow written and LED computed from the new shadow in the same edge, via next-state shadow).
- The page output always equals the index of the page whose contents LED holds.
- Mode change mid-dwell: leaving auto clears the counter; switching source only (bit1) does not disturb page or counter.
- No handshake back-pressure; all inputs are sampled synchronously. snap and step are assumed already debounced and single-cycle.

Decomposition:
- Shared package: mode encodings (MODE_MAN_LIVE=0, MODE_AUTO_LIVE=1, MODE_MAN_SNAP=2, MODE_AUTO_SNAP=3), flag-bit positions (ZF_BIT=0, OF_BIT=LED_W-1).
- Sub-module led_dwell_timer (params DWELL): inputs clk, rst_n, en, clr; output tick. Holds the counter and produces the advance pulse.
- Page select/slice logic stays inline.

Test Plan:
Bench uses DATA_W=32, NUM_CH=2, LED_W=8, DWELL=4, so NPAGE=9 and PW=4.
- Reset: assert rst_n=0 mid-cycle with din nonzero -> LED=0x00 and page=0 immediately, held until release.
- Manual live: din={32'hCAFEBABE, 32'h12345678}; sel=0,1,3,4,7 -> LED one cycle later = 0x78, 0x56, 0x12, 0xBE, 0xCA.
- Flag and out-of-range: ofa=1, zfa=1; sel=8 then sel=15 -> LED=0x81 for both, page=8 for both. ofa=0, zfa=1 -> 0x01.
- Auto wrap: mode=1 from page 7 -> page 8 after 4 cycles, page 0 after 8 cycles. Inject step on the cycle dwell expires -> exactly one advance; the next advance comes 4 cycles later.
- Snapshot freeze: din=32'hAABBCCDD on ch0, snap pulse, then din changed to 0; mode=2, sel=2 -> LED=0xBB. A new snap with mode=2 held -> LED updates one cycle after the snap edge.
- Mode change: auto at page 5 mid-dwell, switch to mode=0 with sel=2 -> page=2 next cycle. Switch back to auto -> continues from 2, next advance after a full DWELL.

Source files
------------

// File: rtl/led_page_scanner_pkg.sv
// Purpose: shared constants for the LED page scanner (mode encodings, flag-page bit positions).
// Latency: n/a (constants only).
// Backpressure: n/a.
package led_page_scanner_pkg;

  // mode[0] selects auto-scan, mode[1] selects the frozen snapshot as source
  localparam logic [1:0] MODE_MAN_LIVE  = 2'd0;
  localparam logic [1:0] MODE_AUTO_LIVE = 2'd1;
  localparam logic [1:0] MODE_MAN_SNAP  = 2'd2;
  localparam logic [1:0] MODE_AUTO_SNAP = 2'd3;

  // Flag page layout: zero flag on the lowest LED, overflow on the highest
  localparam int ZF_BIT = 0;

  function automatic int of_bit(input int led_w);
    return led_w - 1;
  endfunction

endpackage

// File: rtl/led_page_scanner_if.sv
// Purpose: signal bundle between the CPU datapath side and the LED page scanner.
// Latency: n/a (wires only).
// Backpressure: none; every signal is sampled synchronously by the scanner.
// Ports: master drives din/ofa/zfa/sel/mode/snap/step and reads LED/page; slave is the scanner.
interface led_page_scanner_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int LED_W  = 8,
  parameter int PW     = 4
);

  logic [NUM_CH*DATA_W-1:0] din;
  logic                     ofa;
  logic                     zfa;
  logic [PW-1:0]            sel;
  logic [1:0]               mode;
  logic                     snap;
  logic                     step;
  logic [LED_W-1:0]         LED;
  logic [PW-1:0]            page;

  modport master (
    output din, ofa, zfa, sel, mode, snap, step,
    input  LED, page
  );

  modport slave (
    input  din, ofa, zfa, sel, mode, snap, step,
    output LED, page
  );

endinterface

// File: rtl/led_dwell_timer.sv
// Purpose: page dwell counter for auto-scan; counts 0..DWELL-1 while enabled and pulses tick on the last count.
// Latency: tick is combinational from the counter; counter updates each clock.
// Backpressure: none.
// Ports: clk, rst_n (async active-low), en (count enable, low holds counter at 0), clr (restart at 0), tick (advance pulse).
module led_dwell_timer #(
  parameter int DWELL = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == LAST);

  // clr and tick both restart the dwell, so a manual step landing on expiry is one advance
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en || clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_page_scanner.sv
// Purpose: shows NUM_CH data words plus a flag page on an LED bank, manual or auto-scanned, live or snapshot.
// Latency: 1 cycle from sel/advance/data/snap to LED; page always names what LED shows.
// Backpressure: none; inputs sampled every clock.
// Ports: clk, rst_n (async active-low), bus (slave: din/ofa/zfa/sel/mode/snap/step in, LED/page out).
module led_page_scanner
  import led_page_scanner_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2,
  parameter int LED_W  = 8,
  parameter int DWELL  = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_page_scanner_if.slave    bus
);

  localparam int LPC     = DATA_W / LED_W;
  localparam int NPAGE   = NUM_CH * LPC + 1;
  localparam int PW      = $clog2(NPAGE);
  localparam int FLAG_PG = NPAGE - 1;
  localparam int OF_POS  = of_bit(LED_W);

  logic auto_mode;
  logic use_shadow;
  logic tick;
  logic adv;

  logic [PW-1:0]            page_q, page_d;
  logic [LED_W-1:0]         led_q, led_d;
  logic [NUM_CH*DATA_W-1:0] sh_din_q, sh_din_d;
  logic                     sh_of_q, sh_of_d;
  logic                     sh_zf_q, sh_zf_d;

  logic [NUM_CH*DATA_W-1:0] src_din;
  logic                     src_of;
  logic                     src_zf;

  always_comb begin
    auto_mode  = 1'b0;
    use_shadow = 1'b0;
    case (bus.mode)
      MODE_MAN_LIVE:  begin auto_mode = 1'b0; use_shadow = 1'b0; end
      MODE_AUTO_LIVE: begin auto_mode = 1'b1; use_shadow = 1'b0; end
      MODE_MAN_SNAP:  begin auto_mode = 1'b0; use_shadow = 1'b1; end
      MODE_AUTO_SNAP: begin auto_mode = 1'b1; use_shadow = 1'b1; end
      default:        begin auto_mode = 1'b0; use_shadow = 1'b0; end
    endcase
  end

  led_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (auto_mode),
    .clr   (auto_mode & bus.step),
    .tick  (tick)
  );

  assign adv = auto_mode & (tick | bus.step);

  // Snapshot is captured in every mode
  always_comb begin
    sh_din_d = sh_din_q;
    sh_of_d  = sh_of_q;
    sh_zf_d  = sh_zf_q;
    if (bus.snap) begin
      sh_din_d = bus.din;
      sh_of_d  = bus.ofa;
      sh_zf_d  = bus.zfa;
    end
  end

  // Next-state shadow feeds the display so a snap is visible on the same edge it is taken
  assign src_din = use_shadow ? sh_din_d : bus.din;
  assign src_of  = use_shadow ? sh_of_d  : bus.ofa;
  assign src_zf  = use_shadow ? sh_zf_d  : bus.zfa;

  always_comb begin
    page_d = page_q;
    if (auto_mode) begin
      if (adv) begin
        page_d = (page_q == PW'(FLAG_PG)) ? '0 : page_q + PW'(1);
      end
    end else if ({1'b0, bus.sel} >= (PW+1)'(NPAGE)) begin
      page_d = PW'(FLAG_PG);
    end else begin
      page_d = bus.sel;
    end
  end

  // Channels are contiguous in din, so data page p is simply slice p of the flat bus
  always_comb begin
    led_d = '0;
    if (page_d == PW'(FLAG_PG)) begin
      led_d[ZF_BIT] = src_zf;
      led_d[OF_POS] = src_of;
    end else begin
      for (int p = 0; p < FLAG_PG; p++) begin
        if (page_d == PW'(p)) begin
          led_d = src_din[p*LED_W +: LED_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q   <= '0;
      led_q    <= '0;
      sh_din_q <= '0;
      sh_of_q  <= 1'b0;
      sh_zf_q  <= 1'b0;
    end else begin
      page_q   <= page_d;
      led_q    <= led_d;
      sh_din_q <= sh_din_d;
      sh_of_q  <= sh_of_d;
      sh_zf_q  <= sh_zf_d;
    end
  end

  assign bus.LED  = led_q;
  assign bus.page = page_q;

endmodule

// File: tb/tb_led_page_scanner.sv
module tb_led_page_scanner;

  localparam int NPAGE = 9;
  localparam int DWELL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  led_page_scanner_if #(.NUM_CH(2), .DATA_W(32), .LED_W(8), .PW(4)) bus ();

  led_page_scanner #(
    .DATA_W (32),
    .NUM_CH (2),
    .LED_W  (8),
    .DWELL  (DWELL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] seq;
    logic [7:0]  led;
    logic [3:0]  page;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   seq    = 0;

  // Reference model state: current page index, cycles spent on it, snapshot copy
  int          m_page;
  int          m_cnt;
  logic [63:0] m_sh_din;
  logic        m_sh_of;
  logic        m_sh_zf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_page   = 0;
    m_cnt    = 0;
    m_sh_din = '0;
    m_sh_of  = 1'b0;
    m_sh_zf  = 1'b0;
  endtask

  // Apply one cycle of inputs and queue what the display must show after the edge
  task automatic drive(input logic [63:0] d, input logic o, input logic z,
                       input logic [3:0] s, input logic [1:0] m,
                       input logic sn, input logic st);
    logic [63:0] src;
    logic        so;
    logic        sz;
    logic [7:0]  led;
    exp_t        e;
    @(negedge clk);
    bus.din  = d;
    bus.ofa  = o;
    bus.zfa  = z;
    bus.sel  = s;
    bus.mode = m;
    bus.snap = sn;
    bus.step = st;
    if (sn) begin
      m_sh_din = d;
      m_sh_of  = o;
      m_sh_zf  = z;
    end
    if (m[0]) begin
      if (st || m_cnt == DWELL - 1) begin
        m_cnt  = 0;
        m_page = (m_page + 1) % NPAGE;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt  = 0;
      m_page = (int'(s) >= NPAGE) ? NPAGE - 1 : int'(s);
    end
    src = m[1] ? m_sh_din : d;
    so  = m[1] ? m_sh_of  : o;
    sz  = m[1] ? m_sh_zf  : z;
    if (m_page == NPAGE - 1) led = {so, 6'b0, sz};
    else                     led = 8'(src >> (m_page * 8));
    e.seq  = 16'(seq);
    e.led  = led;
    e.page = 4'(m_page);
    seq++;
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: the display updates every cycle, so each edge consumes one expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("led[%0d]", e.seq), 32'(bus.LED), 32'(e.led));
        chk($sformatf("page[%0d]", e.seq), 32'(bus.page), 32'(e.page));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish before t=200000");
    $fatal(1);
  end

  localparam logic [63:0] DIN_A = {32'hCAFEBABE, 32'h12345678};

  initial begin : stim
    logic [1:0] rmode;
    bus.din  = '0;
    bus.ofa  = 1'b0;
    bus.zfa  = 1'b0;
    bus.sel  = '0;
    bus.mode = 2'd0;
    bus.snap = 1'b0;
    bus.step = 1'b0;
    model_reset();

    // Power-up reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_led", 32'(bus.LED), 32'h0);
    chk("rst_page", 32'(bus.page), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Manual live pages
    drive(DIN_A, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0); after_edge(); chk("man_p0", 32'(bus.LED), 32'h78);
    drive(DIN_A, 1'b0, 1'b0, 4'd1, 2'd0, 1'b0, 1'b0); after_edge(); chk("man_p1", 32'(bus.LED), 32'h56);
    drive(DIN_A, 1'b0, 1'b0, 4'd3, 2'd0, 1'b0, 1'b0); after_edge(); chk("man_p3", 32'(bus.LED), 32'h12);
    drive(DIN_A, 1'b0, 1'b0, 4'd4, 2'd0, 1'b0, 1'b0); after_edge(); chk("man_p4", 32'(bus.LED), 32'hBE);
    drive(DIN_A, 1'b0, 1'b0, 4'd7, 2'd0, 1'b0, 1'b0); after_edge(); chk("man_p7", 32'(bus.LED), 32'hCA);

    // Flag page and out-of-range select
    drive(DIN_A, 1'b1, 1'b1, 4'd8, 2'd0, 1'b0, 1'b0); after_edge();
    chk("flag8_led", 32'(bus.LED), 32'h81); chk("flag8_page", 32'(bus.page), 32'd8);
    drive(DIN_A, 1'b1, 1'b1, 4'd15, 2'd0, 1'b0, 1'b0); after_edge();
    chk("flag15_led", 32'(bus.LED), 32'h81); chk("flag15_page", 32'(bus.page), 32'd8);
    drive(DIN_A, 1'b0, 1'b1, 4'd15, 2'd0, 1'b0, 1'b0); after_edge();
    chk("flag_zf_led", 32'(bus.LED), 32'h01);

    // Asynchronous reset mid-cycle with live data present
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_led", 32'(bus.LED), 32'h0);
    chk("midrst_page", 32'(bus.page), 32'h0);
    @(negedge clk);
    chk("midrst_hold_led", 32'(bus.LED), 32'h0);
    @(negedge clk);
    chk("midrst_hold_page", 32'(bus.page), 32'h0);
    rst_n = 1'b1;
    model_reset();

    // Auto-scan from page 7 with wrap, then a step on the expiry cycle
    drive(DIN_A, 1'b1, 1'b0, 4'd7, 2'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      drive(DIN_A, 1'b1, 1'b0, 4'd0, 2'd1, 1'b0, (i == 12));
      after_edge();
      if (i == 3)  chk("auto_hold7", 32'(bus.page), 32'd7);
      if (i == 4)  chk("auto_to8", 32'(bus.page), 32'd8);
      if (i == 4)  chk("auto_flag_led", 32'(bus.LED), 32'h80);
      if (i == 8)  chk("auto_wrap0", 32'(bus.page), 32'd0);
      if (i == 12) chk("auto_step_single", 32'(bus.page), 32'd1);
      if (i == 15) chk("auto_after_step_hold", 32'(bus.page), 32'd1);
      if (i == 16) chk("auto_after_step_adv", 32'(bus.page), 32'd2);
    end

    // Snapshot freeze and re-snap while frozen
    drive(64'h0000_0000_AABB_CCDD, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
    drive(64'h0, 1'b0, 1'b0, 4'd2, 2'd2, 1'b0, 1'b0); after_edge();
    chk("snap_frozen", 32'(bus.LED), 32'hBB);
    drive(64'h0000_0000_1122_3344, 1'b0, 1'b0, 4'd2, 2'd2, 1'b1, 1'b0); after_edge();
    chk("snap_resnap", 32'(bus.LED), 32'h22);
    drive(64'h0, 1'b0, 1'b0, 4'd2, 2'd2, 1'b0, 1'b0); after_edge();
    chk("snap_hold", 32'(bus.LED), 32'h22);

    // Leave auto mid-dwell, then re-enter
    drive(DIN_A, 1'b0, 1'b0, 4'd5, 2'd0, 1'b0, 1'b0);
    drive(DIN_A, 1'b0, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0);
    drive(DIN_A, 1'b0, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0);
    drive(DIN_A, 1'b0, 1'b0, 4'd2, 2'd0, 1'b0, 1'b0); after_edge();
    chk("modechg_man", 32'(bus.page), 32'd2);
    for (int i = 1; i <= 4; i++) begin
      drive(DIN_A, 1'b0, 1'b0, 4'd0, 2'd1, 1'b0, 1'b0);
      after_edge();
      if (i == 3) chk("reauto_hold", 32'(bus.page), 32'd2);
      if (i == 4) chk("reauto_adv", 32'(bus.page), 32'd3);
    end

    // Randomized traffic checked only by the scoreboard
    rmode = 2'd1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) rmode = 2'($urandom_range(0, 3));
      drive({$urandom, $urandom}, 1'($urandom), 1'($urandom),
            4'($urandom_range(0, 15)), rmode,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
